// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for a 1-bit 4x1 multiplexer.
// Steps the select lines S1:S0 through channels 0..3. Each channel is held
// for DWELL cycles, and D is sampled on the last cycle of each dwell.
// The four samples are assembled into the frame q, with q[k] = channel k.
// Optional feature macro: MUX_SCAN_PARITY_EN adds output par = ^q.
module mux_scan_ctrl #(
    parameter int DWELL = 2  // cycles per channel, legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       D,
    output logic       S1,
    output logic       S0,
    output logic [3:0] q,
    output logic       busy,
`ifdef MUX_SCAN_PARITY_EN
    output logic       done,
    output logic       par
`else
    output logic       done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ch,     w_ch_nxt;
    logic [7:0] r_cnt,    w_cnt_nxt;
    logic [2:0] r_shadow, w_shadow_nxt;  // samples of channels 0..2
    logic [3:0] r_q,      w_q_nxt;
    logic       w_dwell_end;

    assign w_dwell_end = (r_cnt == CNT_LAST);

    // Next-state and datapath update logic for the scan sequence
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_q_nxt      = r_q;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_ch_nxt    = 2'd0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_SCAN: begin
                if (w_dwell_end) begin
                    w_cnt_nxt = 8'd0;
                    case (r_ch)
                        2'd0: w_shadow_nxt[0] = D;
                        2'd1: w_shadow_nxt[1] = D;
                        2'd2: w_shadow_nxt[2] = D;
                        default: begin
                            // Last channel: D goes straight into the frame
                            w_q_nxt     = {D, r_shadow};
                            w_state_nxt = ST_DONE;
                        end
                    endcase
                    if (r_ch != 2'd3) begin
                        w_ch_nxt = r_ch + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                // Select stays on channel 3 for this cycle, then rewinds
                w_ch_nxt    = 2'd0;
                w_cnt_nxt   = 8'd0;
                w_state_nxt = cont ? ST_SCAN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ch_nxt    = 2'd0;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // FSM state register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Channel, dwell counter, shadow samples and output frame registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch     <= 2'd0;
            r_cnt    <= 8'd0;
            r_shadow <= 3'd0;
            r_q      <= 4'd0;
        end else begin
            r_ch     <= w_ch_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_q      <= w_q_nxt;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_par;

    // Parity tracks the frame and is written whenever q is written
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ^w_q_nxt;
        end
    end

    assign par = r_par;
`endif

    // Select lines come straight from the channel register, so they are glitch-free
    assign S1   = r_ch[1];
    assign S0   = r_ch[0];
    assign q    = r_q;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl. A behavioural 4x1 mux closes the
// loop from S1/S0 to D. A second instance with DWELL=1 covers the minimum
// dwell time.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cont;
    logic [3:0] a;
    logic       D, S1, S0, busy, done;
    logic [3:0] q;

    logic       start1;
    logic [3:0] a1;
    logic       D1, S1_1, S0_1, busy1, done1;
    logic [3:0] q1;

    int n_checks = 0;
    int n_fail   = 0;

    // 4x1 multiplexers driven by the sequencers
    assign D  = a[{S1, S0}];
    assign D1 = a1[{S1_1, S0_1}];

`ifdef MUX_SCAN_PARITY_EN
    logic par, par1;
`endif

    mux_scan_ctrl #(.DWELL(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cont  (cont),
        .D     (D),
        .S1    (S1),
        .S0    (S0),
        .q     (q),
        .busy  (busy),
`ifdef MUX_SCAN_PARITY_EN
        .done  (done),
        .par   (par)
`else
        .done  (done)
`endif
    );

    mux_scan_ctrl #(.DWELL(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .cont  (1'b0),
        .D     (D1),
        .S1    (S1_1),
        .S0    (S0_1),
        .q     (q1),
        .busy  (busy1),
`ifdef MUX_SCAN_PARITY_EN
        .done  (done1),
        .par   (par1)
`else
        .done  (done1)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle; outputs are observed 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first SCAN cycle of a DWELL=2 frame. Checks the select
    // sequence and returns in the DONE cycle after checking the frame.
    task automatic scan_frame(input logic [3:0] exp_q, input bit poke_start,
                              input bit drop_cont);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("sel_c%0d", j), 8'({S1, S0}), 8'(j / 2));
            check($sformatf("busy_c%0d", j), 8'(busy), 8'd1);
            check($sformatf("done_c%0d", j), 8'(done), 8'd0);
            if (poke_start) start = (j % 2 == 1);
            if (drop_cont && j == 3) cont = 1'b0;
            tick();
        end
        start = 1'b0;
        check("done_pulse", 8'(done), 8'd1);
        check("q_frame", 8'(q), 8'(exp_q));
        check("sel_in_done", 8'({S1, S0}), 8'd3);
        check("busy_in_done", 8'(busy), 8'd1);
`ifdef MUX_SCAN_PARITY_EN
        check("par_frame", 8'(par), 8'(^exp_q));
`endif
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        cont   = 1'b0;
        a      = 4'b0000;
        start1 = 1'b0;
        a1     = 4'b0000;
        tick();
        tick();
        check("rst_q", 8'(q), 8'd0);
        check("rst_sel", 8'({S1, S0}), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        rst = 1'b0;

        // Single-shot frame, a3..a0 = 1,1,0,1
        a     = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_frame(4'b1101, 1'b0, 1'b0);
        tick();
        check("ss_idle_busy", 8'(busy), 8'd0);
        check("ss_idle_done", 8'(done), 8'd0);
        check("ss_idle_sel", 8'({S1, S0}), 8'd0);
        check("ss_q_hold", 8'(q), 8'b1101);

        // Continuous frames; start poked during frame 1, inputs changed in DONE
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_frame(4'b1101, 1'b1, 1'b0);
        a = 4'b0110;
        tick();
        check("cont_no_gap_busy", 8'(busy), 8'd1);
        check("cont_no_gap_done", 8'(done), 8'd0);
        scan_frame(4'b0110, 1'b0, 1'b1);
        tick();
        check("cont_end_busy", 8'(busy), 8'd0);
        check("cont_end_done", 8'(done), 8'd0);
        check("cont_end_q", 8'(q), 8'b0110);
        tick();
        check("cont_stays_idle", 8'(busy), 8'd0);

        // Reset mid-scan while channel 2 is selected
        a     = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_frame(4'b1101, 1'b0, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_sel_ch2", 8'({S1, S0}), 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_q", 8'(q), 8'd0);
        check("mid_rst_sel", 8'({S1, S0}), 8'd0);
        check("mid_rst_busy", 8'(busy), 8'd0);
        check("mid_rst_done", 8'(done), 8'd0);
`ifdef MUX_SCAN_PARITY_EN
        check("mid_rst_par", 8'(par), 8'd0);
`endif
        for (int k = 0; k < 10; k++) begin
            check("post_rst_no_done", 8'(done), 8'd0);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_frame(4'b1101, 1'b0, 1'b0);
        tick();
        check("post_rst_idle", 8'(busy), 8'd0);

        // DWELL=1: the select changes every cycle
        a1     = 4'b1010;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("d1_sel_c%0d", k), 8'({S1_1, S0_1}), 8'(k));
            check($sformatf("d1_done_c%0d", k), 8'(done1), 8'd0);
            tick();
        end
        check("d1_done", 8'(done1), 8'd1);
        check("d1_q", 8'(q1), 8'b1010);
`ifdef MUX_SCAN_PARITY_EN
        check("d1_par", 8'(par1), 8'd0);
`endif
        tick();
        check("d1_idle_busy", 8'(busy1), 8'd0);
        check("d1_idle_done", 8'(done1), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 1-bit 4x1 multiplexer. It drives the mux select lines S1/S0 and consumes the mux output D.
- Steps S1:S0 through channels 0..3, holds each channel for a programmable dwell time and samples D at the end of each dwell.
- Assembles the four samples into a 4-bit parallel frame q, with q[k] = value of mux input a_k.
- Used for time-division readout of four 1-bit sources over a single wire. Supports single-shot and continuous modes with a start/busy/done handshake.

Parameters:
DWELL, 2, clock cycles each channel is held on S1:S0 (legal range 1..255); D is sampled on the last cycle of each dwell.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a frame; honoured only in IDLE
cont  input  1  continuous mode; sampled in DONE state
D  input  1  mux output being scanned
S1  output  1  mux select MSB (registered)
S0  output  1  mux select LSB (registered)
q  output  4  last completed frame, q[k] = sample of channel k
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse: q has just been updated

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, ch=0, dwell counter=0, shadow=0, q=4'b0000, S1=S0=0, busy=0, done=0.
  - rst has priority over every other input.
- Reset mid-scan aborts the frame: no done pulse, q cleared to 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - S1:S0=00, busy=0, done=0.
  - start=1 at an edge -> SCAN with ch=0 and cnt=0.
- SCAN:
  - S1:S0 = ch (2-bit), busy=1.
  - cnt increments each cycle from 0 to DWELL-1.
  - At an edge with cnt==DWELL-1: shadow[ch]<=D and cnt<=0.
    - If ch<3: ch<=ch+1.
    - If ch==3: q<={D, shadow[2:0]}, done<=1, state -> DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=1, S1:S0 stays 11.
  - cont=1 -> SCAN with ch=0, cnt=0 (back-to-back frames, no IDLE gap).
  - cont=0 -> IDLE.
- Timing:
  - With start sampled at edge E0, S1:S0 shows channel k during cycles E0+k*DWELL .. E0+(k+1)*DWELL-1.
  - done is high in the cycle following edge E0+4*DWELL. Frame latency is 4*DWELL+1 cycles.
  - Continuous mode gives a frame period of 4*DWELL+1 cycles.
- start is ignored while busy=1 and produces no queued request. start held high in IDLE starts a new frame on every return to IDLE.
- cont is ignored outside DONE. Deasserting cont mid-frame lets the current frame complete, then the block goes to IDLE.
- q holds its value between done pulses. Only the transition into DONE writes q.
- D is treated as a synchronous input. The dwell of at least 1 cycle gives the mux a full cycle to settle after each select change.
- ch wraps only via the DONE/SCAN path. The counter never exceeds 3, and cnt never exceeds DWELL-1.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- When defined:
  - Adds output port par (1 bit), register = ^ of the frame written to q, updated in the same cycle as q.
  - Reset value 0; cleared on reset mid-scan.
- When undefined: port par is absent and no parity logic is generated. All other behaviour is identical.

Test Plan:
- Bench instantiates the 4x1 mux with S1/S0 from this block and D back into it; a3..a0=1,1,0,1, DWELL=2, start pulse at edge E0, cont=0 -> S1:S0 sequence 00,00,01,01,10,10,11,11; done high exactly one cycle after E0+8; q=4'b1101; busy falls the following cycle.
- Continuous: cont=1, inputs changed to a3..a0=0,1,1,0 during the first frame's DONE cycle -> second done 9 cycles after the first, q=4'b0110, no IDLE cycle between frames; cont dropped mid-frame 2 -> frame 2 completes, then IDLE.
- start pulsed repeatedly during SCAN -> ignored; exactly one done per frame, frame timing unchanged.
- rst=1 while ch=2 after a previous frame left q=4'b1101 -> next cycle q=0, S1:S0=00, busy=0, no done pulse; a new start produces a normal frame.
- DWELL=1 boundary: a3..a0=1,0,1,0 -> S1:S0 changes every cycle, done 5 cycles after start, q=4'b1010.
- MUX_SCAN_PARITY_EN defined: frames 4'b1101 then 4'b0110 -> par=1, then par=0, each coincident with done; after rst, par=0.
